booth_multiplier: RTL and testbench

Sequential 5x5 signed radix-2 Booth multiplier producing a 10-bit two's-complement product. Both operands arrive over one shared 5-bit input bus on consecutive cycles after a start request. Controller/datapath block with ready/done handshake, intended as a small arithmetic slave fed by a bus master.

---
 rtl/booth_multiplier_if.sv | 13 +
 rtl/booth_multiplier.sv | 100 ++++++++++
 tb/tb_booth_multiplier.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/booth_multiplier_if.sv
// Operand/handshake bundle between a bus master and the Booth multiplier slave.
// state mirrors the controller FSM for observation only.
interface booth_multiplier_if;
  logic [4:0] inbus;
  logic       start;
  logic       done;
  logic       ready;
  logic [9:0] result;
  logic [2:0] state;

  modport slave  (input inbus, start, output done, ready, result, state);
  modport master (output inbus, start, input done, ready, result, state);
endinterface

// File: rtl/booth_multiplier.sv
// Sequential 5x5 signed radix-2 Booth multiplier with a 10-bit product.
// Operands arrive on one shared bus on the two cycles after start.
module booth_multiplier (
  input logic               clk,
  input logic               rst,
  booth_multiplier_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_A = 3'd1,
    GET_B = 3'd2,
    CALC  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  m_q, m_d;
  logic [5:0]  a_q, a_d;
  logic [4:0]  q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [9:0]  result_q, result_d;
  logic [5:0]  m_ext;
  logic [5:0]  sum;

  // Six-bit accumulator keeps -(-16) = +16 representable.
  always_comb begin
    m_ext = {m_q[4], m_q};
    case ({q_q[0], qm1_q})
      2'b01:   sum = a_q + m_ext;
      2'b10:   sum = a_q - m_ext;
      default: sum = a_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    a_d      = a_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = GET_A;
      end
      GET_A: begin
        m_d     = bus.inbus;
        state_d = GET_B;
      end
      GET_B: begin
        q_d     = bus.inbus;
        a_d     = 6'd0;
        qm1_d   = 1'b0;
        cnt_d   = 3'd5;
        state_d = CALC;
      end
      CALC: begin
        a_d   = {sum[5], sum[5:1]};
        q_d   = {sum[0], q_q[4:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          result_d = {sum[5:1], sum[0], q_q[4:1]};
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      m_q      <= 5'd0;
      a_q      <= 6'd0;
      q_q      <= 5'd0;
      qm1_q    <= 1'b0;
      cnt_q    <= 3'd0;
      result_q <= 10'd0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      a_q      <= a_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.ready  = (state_q == IDLE);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.state  = state_q;
endmodule

// File: tb/tb_booth_multiplier.sv
// Directed-vector bench for booth_multiplier: driver tasks push expected
// products, a negedge monitor pops and compares on every done pulse.
module tb_booth_multiplier;
  logic clk;
  logic rst;
  booth_multiplier_if bus();

  booth_multiplier dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int done_seen = 0;
  logic [9:0] exp_q[$];
  logic [9:0] prev_result = 10'd0;
  logic       prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued product.
  always @(negedge clk) begin
    if (rst && bus.done === 1'b1) begin
      done_seen++;
      if (prev_done) check("done_one_cycle", 32'd1, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("product", {22'd0, bus.result}, {22'd0, e});
      end
    end
    prev_done = rst && (bus.done === 1'b1);
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.ready !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [4:0] a, input logic [4:0] b,
                        input logic [9:0] exp, input bit disturb);
    int k;
    bit got;
    wait_ready();
    bus.start = 1'b1;
    exp_q.push_back(exp);
    got = 1'b0;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.inbus = a;
        bus.start = disturb;
      end else if (k == 2) begin
        bus.inbus = b;
      end else begin
        bus.inbus = disturb ? 5'($urandom_range(0, 31)) : 5'd0;
      end
      if (k == 5) check("result_held", {22'd0, bus.result}, {22'd0, prev_result});
      if (bus.done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    if (!got) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_back());
    end else begin
      check("latency", k, 32'd8);
      prev_result = exp;
      @(negedge clk);
      check("ready_after_done", {31'd0, bus.ready}, 32'd1);
      check("result_after_done", {22'd0, bus.result}, {22'd0, exp});
    end
  endtask

  initial begin
    int done_before;
    bus.start = 1'b0;
    bus.inbus = 5'd0;
    rst = 1'b0;
    #1;
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", {22'd0, bus.result}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.inbus = 5'($urandom_range(0, 31));
    end
    check("idle_ready", {31'd0, bus.ready}, 32'd1);
    check("idle_state", {29'd0, bus.state}, 32'd0);
    check("idle_result", {22'd0, bus.result}, 32'd0);

    run_op(5'd3,  5'd5,  10'h00F, 1'b0);
    run_op(5'h1D, 5'd5,  10'h3F1, 1'b0);
    run_op(5'd7,  5'h1F, 10'h3F9, 1'b1);
    run_op(5'd0,  5'h17, 10'h000, 1'b0);
    run_op(5'h10, 5'h10, 10'h100, 1'b1);
    run_op(5'h10, 5'd15, 10'h310, 1'b0);
    run_op(5'd15, 5'd15, 10'h0E1, 1'b1);
    run_op(5'h1F, 5'h1F, 10'h001, 1'b0);
    run_op(5'd1,  5'h10, 10'h3F0, 1'b1);

    // Abort mid-CALC: no done may follow, result clears.
    done_before = done_seen;
    wait_ready();
    bus.start = 1'b1;
    @(negedge clk); bus.inbus = 5'd9;  bus.start = 1'b0;
    @(negedge clk); bus.inbus = 5'd11;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_ready", {31'd0, bus.ready}, 32'd1);
    check("abort_result", {22'd0, bus.result}, 32'd0);
    for (int i = 0; i < 10; i++) @(negedge clk);
    rst = 1'b1;
    prev_result = 10'd0;
    @(negedge clk);
    check("abort_no_done", done_seen, done_before);

    run_op(5'd2, 5'h1C, 10'h3F8, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    check("done_count", done_seen, 32'd10);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
